// File: rtl/vga_pkg.sv
// Shared raster timing constants and coordinate type for the timing generator and the mappers.
package vga_pkg;

  localparam int unsigned COORD_W = 10;
  typedef logic [COORD_W-1:0] coord_t;

  localparam int unsigned H_ACTIVE_DEF   = 640;
  localparam int unsigned H_FP_DEF       = 16;
  localparam int unsigned H_SYNC_DEF     = 96;
  localparam int unsigned H_BP_DEF       = 48;
  localparam int unsigned V_ACTIVE_DEF   = 480;
  localparam int unsigned V_FP_DEF       = 10;
  localparam int unsigned V_SYNC_DEF     = 2;
  localparam int unsigned V_BP_DEF       = 33;
  localparam int unsigned SYNC_DELAY_DEF = 2;

  localparam int unsigned H_TOTAL_DEF  = H_ACTIVE_DEF + H_FP_DEF + H_SYNC_DEF + H_BP_DEF;
  localparam int unsigned V_TOTAL_DEF  = V_ACTIVE_DEF + V_FP_DEF + V_SYNC_DEF + V_BP_DEF;
  localparam int unsigned HS_START_DEF = H_ACTIVE_DEF + H_FP_DEF;
  localparam int unsigned HS_END_DEF   = HS_START_DEF + H_SYNC_DEF;
  localparam int unsigned VS_START_DEF = V_ACTIVE_DEF + V_FP_DEF;
  localparam int unsigned VS_END_DEF   = VS_START_DEF + V_SYNC_DEF;

endpackage

// File: rtl/sync_delay_line.sv
// Enable-gated shift register; DEPTH=0 collapses to a wire.
module sync_delay_line #(
  parameter int unsigned      WIDTH     = 1,
  parameter int unsigned      DEPTH     = 2,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  if (DEPTH == 0) begin : g_bypass
    logic unused_c;
    assign unused_c = ^{clk, rst_n, en_i};
    assign q_o      = d_i;
  end else begin : g_shift
    logic [WIDTH-1:0] stage_q [DEPTH];

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        for (int unsigned i = 0; i < DEPTH; i++) stage_q[i] <= RESET_VAL;
      end else if (en_i) begin
        stage_q[0] <= d_i;
        for (int unsigned i = 1; i < DEPTH; i++) stage_q[i] <= stage_q[i-1];
      end
    end

    assign q_o = stage_q[DEPTH-1];
  end

endmodule

// File: rtl/vga_timing_gen.sv
// Raster scan counters, blank/sync decode and line/frame strobes for the pixel mappers.
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int unsigned H_ACTIVE   = H_ACTIVE_DEF,
  parameter int unsigned H_FP       = H_FP_DEF,
  parameter int unsigned H_SYNC     = H_SYNC_DEF,
  parameter int unsigned H_BP       = H_BP_DEF,
  parameter int unsigned V_ACTIVE   = V_ACTIVE_DEF,
  parameter int unsigned V_FP       = V_FP_DEF,
  parameter int unsigned V_SYNC     = V_SYNC_DEF,
  parameter int unsigned V_BP       = V_BP_DEF,
  parameter int unsigned SYNC_DELAY = SYNC_DELAY_DEF
) (
  input  logic       vga_clk,
  input  logic       reset_n,
  input  logic       pix_en,
  output logic [9:0] DrawX,
  output logic [9:0] DrawY,
  output logic       blank,
  output logic       hs,
  output logic       vs,
  output logic       line_start,
  output logic       frame_start
);

  localparam int unsigned H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int unsigned HS_START = H_ACTIVE + H_FP;
  localparam int unsigned HS_END   = HS_START + H_SYNC;
  localparam int unsigned VS_START = V_ACTIVE + V_FP;
  localparam int unsigned VS_END   = VS_START + V_SYNC;

  if (H_TOTAL > 1024 || V_TOTAL > 1024) begin : g_size_check
    $error("vga_timing_gen: raster totals exceed the 10-bit counters");
  end

  coord_t hcnt_q, hcnt_d, vcnt_q, vcnt_d;
  coord_t drawx_q, drawx_d, drawy_q, drawy_d;
  logic   blank_q, blank_d;
  logic   hs_raw_q, hs_raw_d, vs_raw_q, vs_raw_d;
  logic   line_start_q, line_start_d, frame_start_q, frame_start_d;
  logic   hwrap_c, vwrap_c;
  logic [1:0] sync_dly_c;

  // hcnt/vcnt run one position ahead; Draw*, blank and raw syncs all register the same point.
  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      hcnt_q        <= '0;
      vcnt_q        <= '0;
      drawx_q       <= '0;
      drawy_q       <= '0;
      blank_q       <= 1'b0;
      hs_raw_q      <= 1'b1;
      vs_raw_q      <= 1'b1;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      hcnt_q        <= hcnt_d;
      vcnt_q        <= vcnt_d;
      drawx_q       <= drawx_d;
      drawy_q       <= drawy_d;
      blank_q       <= blank_d;
      hs_raw_q      <= hs_raw_d;
      vs_raw_q      <= vs_raw_d;
      line_start_q  <= line_start_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign hwrap_c = (hcnt_q == coord_t'(H_TOTAL - 1));
  assign vwrap_c = (vcnt_q == coord_t'(V_TOTAL - 1));

  always_comb begin
    hcnt_d        = hcnt_q;
    vcnt_d        = vcnt_q;
    drawx_d       = drawx_q;
    drawy_d       = drawy_q;
    blank_d       = blank_q;
    hs_raw_d      = hs_raw_q;
    vs_raw_d      = vs_raw_q;
    line_start_d  = 1'b0;
    frame_start_d = 1'b0;
    if (pix_en) begin
      hcnt_d = hwrap_c ? '0 : hcnt_q + coord_t'(1);
      if (hwrap_c) vcnt_d = vwrap_c ? '0 : vcnt_q + coord_t'(1);
      drawx_d       = hcnt_q;
      drawy_d       = vcnt_q;
      blank_d       = (hcnt_q < coord_t'(H_ACTIVE)) && (vcnt_q < coord_t'(V_ACTIVE));
      hs_raw_d      = !((hcnt_q >= coord_t'(HS_START)) && (hcnt_q < coord_t'(HS_END)));
      vs_raw_d      = !((vcnt_q >= coord_t'(VS_START)) && (vcnt_q < coord_t'(VS_END)));
      line_start_d  = (hcnt_q == '0);
      frame_start_d = (hcnt_q == '0) && (vcnt_q == coord_t'(V_ACTIVE));
    end
  end

  // Sync delay matches the mapper colour pipeline latency.
  sync_delay_line #(
    .WIDTH     (2),
    .DEPTH     (SYNC_DELAY),
    .RESET_VAL (2'b11)
  ) u_sync_dly (
    .clk   (vga_clk),
    .rst_n (reset_n),
    .en_i  (pix_en),
    .d_i   ({hs_raw_q, vs_raw_q}),
    .q_o   (sync_dly_c)
  );

  assign DrawX       = drawx_q;
  assign DrawY       = drawy_q;
  assign blank       = blank_q;
  assign hs          = sync_dly_c[1];
  assign vs          = sync_dly_c[0];
  assign line_start  = line_start_q;
  assign frame_start = frame_start_q;

endmodule
